// File: rtl/cpu_ctrl_seq.sv
// Fetch/execute sequencer for the 8-bit accumulator core: two cycles per instruction.
// Optional single-step mode is enabled by defining CPU_CTRL_STEP_EN (adds the step input).
module cpu_ctrl_seq #(
  parameter int PC_W     = 8,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef CPU_CTRL_STEP_EN
  input  logic                step,
`endif
  output logic [PC_W-1:0]     imem_addr,
  input  logic [7:0]          imem_data,
  input  logic                acc_neg,
  input  logic [7:0]          rf_rdata,
  output logic [3:0]          rf_addr,
  output logic [3:0]          imm,
  output logic                acc_we,
  output logic [1:0]          acc_src,
  output logic                alu_op,
  output logic                rf_we,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_LDR = 4'h4,
    OP_STR = 4'h5,
    OP_BRN = 4'h8,
    OP_LDI = 4'hD
  } op_t;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_RF  = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [7:0]      ir, ir_nxt;
  logic            retire_inc;
  logic            fetch_go;

`ifdef CPU_CTRL_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  assign imem_addr = pc;
  assign rf_addr   = ir[3:0];
  assign imm       = ir[3:0];
  assign halted    = (state == S_HALT);

  // Datapath selects follow ir in every state; only the strobes are gated by EXEC.
  always_comb begin
    acc_src = SRC_ALU;
    alu_op  = 1'b0;
    case (ir[7:4])
      OP_SUB:  alu_op  = 1'b1;
      OP_LDR:  acc_src = SRC_RF;
      OP_LDI:  acc_src = SRC_IMM;
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    acc_we     = 1'b0;
    rf_we      = 1'b0;
    illegal    = 1'b0;
    retire_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_go) begin
          ir_nxt    = imem_data;
          pc_nxt    = pc + PC_W'(1);
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        retire_inc = 1'b1;
        state_nxt  = S_FETCH;
        if (ir == 8'hFF) begin
          state_nxt = S_HALT;
        end else begin
          case (ir[7:4])
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_LDR, OP_LDI: acc_we = 1'b1;
            OP_STR: rf_we = 1'b1;
            OP_BRN: if (acc_neg) pc_nxt = PC_W'(rf_rdata);
            default: illegal = 1'b1;
          endcase
        end
      end
      S_HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= 8'h00;
      retired <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      if (retire_inc) retired <= retired + RETIRE_W'(1);
    end
  end

endmodule
